// File: rtl/lsu_issue_queue_if.sv
// Payload type and handshake bundle between dispatch/wakeup/ROB sources and the LSU issue queue.
package lsu_issue_queue_pkg;
    localparam int unsigned PREG_W = 6;
    localparam int unsigned ROB_W  = 5;
    localparam int unsigned IMM_W  = 12;

    typedef struct packed {
        logic              is_load;
        logic              is_store;
        logic              rd_used;
        logic [ROB_W-1:0]  rob_tag;
        logic [PREG_W-1:0] prd;
        logic [1:0]        ls_size;
        logic              unsigned_load;
        logic [IMM_W-1:0]  imm;
    } rs_entry_t;
endpackage

interface lsu_issue_queue_if #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned NUM_WB = 2
) ();
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned PREG_W = lsu_issue_queue_pkg::PREG_W;
    localparam int unsigned ROB_W  = lsu_issue_queue_pkg::ROB_W;

    logic                                flush_i;
    logic                                disp_valid_i;
    logic                                disp_ready_o;
    lsu_issue_queue_pkg::rs_entry_t      disp_entry_i;
    logic [PREG_W-1:0]                   disp_prs1_i;
    logic [PREG_W-1:0]                   disp_prs2_i;
    logic                                disp_rdy1_i;
    logic                                disp_rdy2_i;
    logic [NUM_WB-1:0]                   wb_valid_i;
    logic [NUM_WB-1:0]                   wb_rd_used_i;
    logic [NUM_WB-1:0][PREG_W-1:0]       wb_prd_i;
    logic [ROB_W-1:0]                    rob_head_tag_i;
    logic                                issue_valid_o;
    lsu_issue_queue_pkg::rs_entry_t      issue_entry_o;
    logic [PREG_W-1:0]                   issue_prs1_o;
    logic [PREG_W-1:0]                   issue_prs2_o;
    logic [CNT_W-1:0]                    count_o;

    modport master (
        output flush_i, disp_valid_i, disp_entry_i, disp_prs1_i, disp_prs2_i,
               disp_rdy1_i, disp_rdy2_i, wb_valid_i, wb_rd_used_i, wb_prd_i, rob_head_tag_i,
        input  disp_ready_o, issue_valid_o, issue_entry_o, issue_prs1_o, issue_prs2_o, count_o
    );

    modport slave (
        input  flush_i, disp_valid_i, disp_entry_i, disp_prs1_i, disp_prs2_i,
               disp_rdy1_i, disp_rdy2_i, wb_valid_i, wb_rd_used_i, wb_prd_i, rob_head_tag_i,
        output disp_ready_o, issue_valid_o, issue_entry_o, issue_prs1_o, issue_prs2_o, count_o
    );
endinterface

// File: rtl/lsu_issue_queue.sv
// In-order load/store issue queue: FIFO of dispatched memory ops with operand wakeup,
// issuing the head to the LSU once operands (and, for stores, ROB-head status) allow.
module lsu_issue_queue
    import lsu_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned NUM_WB = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    lsu_issue_queue_if.slave q
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    rs_entry_t         payload_q [DEPTH];
    logic [PREG_W-1:0] prs1_q    [DEPTH];
    logic [PREG_W-1:0] prs2_q    [DEPTH];
    logic [DEPTH-1:0]  valid_q, rdy1_q, rdy2_q;
    logic [DEPTH-1:0]  valid_d, rdy1_d, rdy2_d;
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;

    logic [DEPTH-1:0]  wake1, wake2;
    logic              disp_wake1, disp_wake2;
    rs_entry_t         head_entry;
    logic              head_ok;
    logic              issue_fire;
    logic              disp_fire;

    // Head eligibility: loads need only the base; stores also need data and ROB-head status.
    assign head_entry = payload_q[head_q];
    assign head_ok    = valid_q[head_q] && rdy1_q[head_q] &&
                        (head_entry.is_load ||
                         (rdy2_q[head_q] && (head_entry.rob_tag == q.rob_head_tag_i)));
    assign issue_fire = head_ok && !q.flush_i;

    assign q.issue_valid_o = issue_fire;
    assign q.issue_entry_o = issue_fire ? head_entry : '0;
    assign q.issue_prs1_o  = prs1_q[head_q];
    assign q.issue_prs2_o  = prs2_q[head_q];
    assign q.count_o       = count_q;
    // Only the registered count gates dispatch; a same-cycle pop does not open a slot.
    assign q.disp_ready_o  = (count_q < CNT_W'(DEPTH));
    assign disp_fire       = q.disp_valid_i && q.disp_ready_o && !q.flush_i;

    // Writeback tag match against live entries and the op being dispatched this cycle.
    always_comb begin
        wake1      = '0;
        wake2      = '0;
        disp_wake1 = 1'b0;
        disp_wake2 = 1'b0;
        for (int p = 0; p < int'(NUM_WB); p++) begin
            if (q.wb_valid_i[p] && q.wb_rd_used_i[p]) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (valid_q[i] && (prs1_q[i] == q.wb_prd_i[p])) wake1[i] = 1'b1;
                    if (valid_q[i] && (prs2_q[i] == q.wb_prd_i[p])) wake2[i] = 1'b1;
                end
                if (q.disp_prs1_i == q.wb_prd_i[p]) disp_wake1 = 1'b1;
                if (q.disp_prs2_i == q.wb_prd_i[p]) disp_wake2 = 1'b1;
            end
        end
    end

    // Next valid/ready vectors: wakeups, then dispatch at tail, then pop at head.
    always_comb begin
        valid_d = valid_q;
        rdy1_d  = rdy1_q | wake1;
        rdy2_d  = rdy2_q | wake2;
        if (disp_fire) begin
            valid_d[tail_q] = 1'b1;
            rdy1_d[tail_q]  = q.disp_rdy1_i | disp_wake1;
            rdy2_d[tail_q]  = q.disp_rdy2_i | disp_wake2;
        end
        if (issue_fire) begin
            valid_d[head_q] = 1'b0;
            rdy1_d[head_q]  = 1'b0;
            rdy2_d[head_q]  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                payload_q[i] <= '0;
                prs1_q[i]    <= '0;
                prs2_q[i]    <= '0;
            end
        end else if (q.flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rdy1_q  <= rdy1_d;
            rdy2_q  <= rdy2_d;
            if (disp_fire) begin
                payload_q[tail_q] <= q.disp_entry_i;
                prs1_q[tail_q]    <= q.disp_prs1_i;
                prs2_q[tail_q]    <= q.disp_prs2_i;
                tail_q            <= tail_q + PTR_W'(1);
            end
            if (issue_fire) head_q <= head_q + PTR_W'(1);
            case ({disp_fire, issue_fire})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_issue_queue.sv
// Directed bench for lsu_issue_queue with a scoreboard of dispatched ops checked in issue order.
module tb_lsu_issue_queue;
    import lsu_issue_queue_pkg::*;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned NUM_WB = 2;

    typedef struct {
        rs_entry_t         e;
        logic [PREG_W-1:0] p1;
        logic [PREG_W-1:0] p2;
    } exp_t;

    logic clk;
    logic rst_n;
    int   npass;
    int   ntot;
    int   mcount;
    exp_t sb[$];

    lsu_issue_queue_if #(.DEPTH(DEPTH), .NUM_WB(NUM_WB)) q ();

    lsu_issue_queue #(.DEPTH(DEPTH), .NUM_WB(NUM_WB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (q.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic rs_entry_t mk(input bit ld, input int tag, input int prd);
        rs_entry_t e;
        e               = '0;
        e.is_load       = ld;
        e.is_store      = !ld;
        e.rd_used       = ld;
        e.rob_tag       = ROB_W'(tag);
        e.prd           = PREG_W'(prd);
        e.ls_size       = 2'(tag);
        e.unsigned_load = ld & tag[0];
        e.imm           = IMM_W'(tag * 37 + 5);
        return e;
    endfunction

    task automatic disp(input rs_entry_t e, input int p1, input int p2, input bit r1, input bit r2);
        q.disp_valid_i = 1'b1;
        q.disp_entry_i = e;
        q.disp_prs1_i  = PREG_W'(p1);
        q.disp_prs2_i  = PREG_W'(p2);
        q.disp_rdy1_i  = r1;
        q.disp_rdy2_i  = r2;
    endtask

    task automatic wake(input int port, input int prd, input bit used);
        q.wb_valid_i[port]   = 1'b1;
        q.wb_rd_used_i[port] = used;
        q.wb_prd_i[port]     = PREG_W'(prd);
    endtask

    // One cycle: check combinational outputs against the model, update model, cross the edge.
    task automatic cyc(input bit exp_iv);
        bit   acc;
        exp_t x;
        #1;
        chk("count", 64'(q.count_o), 64'(mcount));
        chk("disp_ready", 64'(q.disp_ready_o), 64'(mcount < int'(DEPTH)));
        chk("issue_valid", 64'(q.issue_valid_o), 64'(exp_iv));
        if (exp_iv) begin
            if (sb.size() == 0) begin
                ntot++;
                $error("FAIL scoreboard_underflow observed=issue expected=empty");
            end else begin
                x = sb.pop_front();
                chk("issue_entry", 64'(q.issue_entry_o), 64'(x.e));
                chk("issue_prs1", 64'(q.issue_prs1_o), 64'(x.p1));
                chk("issue_prs2", 64'(q.issue_prs2_o), 64'(x.p2));
            end
        end else begin
            chk("idle_entry", 64'(q.issue_entry_o), 64'(0));
        end
        acc = q.disp_valid_i && (mcount < int'(DEPTH)) && !q.flush_i;
        if (q.flush_i) begin
            sb.delete();
            mcount = 0;
        end else begin
            if (acc) begin
                x.e  = q.disp_entry_i;
                x.p1 = q.disp_prs1_i;
                x.p2 = q.disp_prs2_i;
                sb.push_back(x);
            end
            mcount = mcount + int'(acc) - int'(exp_iv);
        end
        @(posedge clk);
        #1;
        q.disp_valid_i = 1'b0;
        q.wb_valid_i   = '0;
        q.flush_i      = 1'b0;
    endtask

    task automatic chk_reset();
        chk("rst_issue_valid", 64'(q.issue_valid_o), 64'(0));
        chk("rst_issue_entry", 64'(q.issue_entry_o), 64'(0));
        chk("rst_prs1", 64'(q.issue_prs1_o), 64'(0));
        chk("rst_prs2", 64'(q.issue_prs2_o), 64'(0));
        chk("rst_disp_ready", 64'(q.disp_ready_o), 64'(1));
        chk("rst_count", 64'(q.count_o), 64'(0));
    endtask

    initial begin
        npass            = 0;
        ntot             = 0;
        mcount           = 0;
        rst_n            = 1'b0;
        q.flush_i        = 1'b0;
        q.disp_valid_i   = 1'b0;
        q.disp_entry_i   = '0;
        q.disp_prs1_i    = '0;
        q.disp_prs2_i    = '0;
        q.disp_rdy1_i    = 1'b0;
        q.disp_rdy2_i    = 1'b0;
        q.wb_valid_i     = '0;
        q.wb_rd_used_i   = '0;
        q.wb_prd_i       = '0;
        q.rob_head_tag_i = '0;
        #3;
        chk_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Ready load issues the cycle after dispatch.
        disp(mk(1, 1, 40), 3, 0, 1, 0); cyc(0);
        cyc(1);
        cyc(0);

        // Load waits for wakeup of prs1=5; no same-cycle bypass.
        disp(mk(1, 2, 41), 5, 0, 0, 0); cyc(0);
        cyc(0);
        cyc(0);
        wake(0, 5, 1); cyc(0);
        cyc(1);

        // Wakeup in the dispatch cycle is captured.
        disp(mk(1, 3, 42), 5, 0, 0, 0); wake(1, 5, 1); cyc(0);
        cyc(1);

        // A writeback with rd_used=0 must not wake.
        disp(mk(1, 4, 43), 9, 0, 0, 0); cyc(0);
        wake(0, 9, 0); cyc(0);
        cyc(0);
        wake(1, 9, 1); cyc(0);
        cyc(1);

        // Store held until its tag reaches ROB head; younger ready load blocked behind it.
        q.rob_head_tag_i = ROB_W'(6);
        disp(mk(0, 7, 0), 11, 12, 1, 1); cyc(0);
        disp(mk(1, 8, 44), 13, 0, 1, 0); cyc(0);
        cyc(0);
        q.rob_head_tag_i = ROB_W'(7);
        cyc(1);
        cyc(1);

        // Store at ROB head still waits on its data operand.
        q.rob_head_tag_i = ROB_W'(9);
        disp(mk(0, 9, 0), 14, 15, 1, 0); cyc(0);
        cyc(0);
        wake(0, 15, 1); cyc(0);
        cyc(1);
        q.rob_head_tag_i = '0;

        // Fill to DEPTH with unready loads; extra dispatches dropped until after a pop.
        for (int i = 0; i < 8; i++) begin
            disp(mk(1, 16 + i, 50 + i), 10 + i, 0, 0, 0); cyc(0);
        end
        disp(mk(1, 29, 60), 3, 0, 1, 0); cyc(0);
        wake(0, 10, 1); cyc(0);
        disp(mk(1, 28, 61), 3, 0, 1, 0); wake(0, 11, 1); wake(1, 12, 1); cyc(1);
        disp(mk(1, 30, 62), 3, 0, 1, 0); wake(0, 13, 1); wake(1, 14, 1); cyc(1);
        wake(0, 15, 1); wake(1, 16, 1); cyc(1);
        wake(0, 17, 1); cyc(1);
        for (int i = 0; i < 5; i++) cyc(1);
        cyc(0);

        // Flush with a ready head suppresses issue and drops the concurrent dispatch.
        for (int i = 0; i < 5; i++) begin
            disp(mk(0, 20 + i, 0), 1, 2, 1, 1); cyc(0);
        end
        q.rob_head_tag_i = ROB_W'(20);
        q.flush_i = 1'b1;
        disp(mk(1, 31, 63), 3, 0, 1, 0); cyc(0);
        q.rob_head_tag_i = '0;
        cyc(0);
        disp(mk(1, 5, 45), 7, 8, 1, 0); cyc(0);
        cyc(1);

        // Asynchronous reset mid-cycle while a store is issuing.
        disp(mk(0, 25, 0), 20, 21, 1, 1); cyc(0);
        disp(mk(0, 26, 0), 22, 23, 1, 1); cyc(0);
        q.rob_head_tag_i = ROB_W'(25);
        #1;
        chk("pre_reset_issue", 64'(q.issue_valid_o), 64'(1));
        rst_n = 1'b0;
        #1;
        chk_reset();
        sb.delete();
        mcount = 0;
        q.rob_head_tag_i = '0;
        #1;
        rst_n = 1'b1;
        cyc(0);
        disp(mk(1, 27, 46), 24, 0, 1, 0); cyc(0);
        cyc(1);
        cyc(0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
